// File: rtl/rom_access_arbiter_if.sv
// Bundle between the ROM access arbiter, its two requesters (IF and LD) and the ROM.
// The slave modport is the arbiter side; master is the requester/ROM side.
interface rom_access_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_data;
    logic              if_misalign;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_gnt;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_misalign;

    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport slave (
        input  if_req, if_addr, ld_req, ld_addr, rom_data,
        output if_gnt, if_valid, if_data, if_misalign,
        output ld_gnt, ld_valid, ld_data, ld_misalign,
        output rom_en, rom_addr
    );

    modport master (
        output if_req, if_addr, ld_req, ld_addr, rom_data,
        input  if_gnt, if_valid, if_data, if_misalign,
        input  ld_gnt, ld_valid, ld_data, ld_misalign,
        input  rom_en, rom_addr
    );
endinterface

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one single-port instruction ROM between the IF and LD
// requesters; one access in flight, misaligned requests answered without a ROM cycle.
module rom_access_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 32,
    parameter int ROM_LAT = 0
) (
    input  logic                clock,
    input  logic                reset,
    rom_access_arbiter_if.slave bus
);
    localparam int CNT_W = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              owner_ld;
    logic              last_ld;
    logic              mis_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] ld_data_q;

    logic              any_req;
    logic              pick_ld;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_mis;
    logic              take;
    logic              capture;

    // LD wins only when IF is idle or IF was the previous owner.
    assign any_req  = bus.if_req | bus.ld_req;
    assign pick_ld  = bus.ld_req & (~bus.if_req | ~last_ld);
    assign sel_addr = pick_ld ? bus.ld_addr : bus.if_addr;
    assign sel_mis  = |sel_addr[1:0];

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && any_req) begin
                    take      = 1'b1;
                    state_nxt = sel_mis ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            owner_ld   <= 1'b0;
            last_ld    <= 1'b1;
            mis_q      <= 1'b0;
            rom_addr_q <= '0;
            if_data_q  <= '0;
            ld_data_q  <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                owner_ld <= pick_ld;
                last_ld  <= pick_ld;
                mis_q    <= sel_mis;
                cnt      <= CNT_W'(ROM_LAT);
                // A misaligned response still counts as a response: it zeroes the word.
                if (!sel_mis) begin
                    rom_addr_q <= sel_addr;
                end else if (pick_ld) begin
                    ld_data_q <= '0;
                end else begin
                    if_data_q <= '0;
                end
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                if (owner_ld) ld_data_q <= bus.rom_data;
                else          if_data_q <= bus.rom_data;
            end
        end
    end

    assign bus.if_gnt      = take & ~pick_ld;
    assign bus.ld_gnt      = take & pick_ld;
    assign bus.if_valid    = (state == RESP) & ~owner_ld;
    assign bus.ld_valid    = (state == RESP) & owner_ld;
    assign bus.if_misalign = (state == RESP) & ~owner_ld & mis_q;
    assign bus.ld_misalign = (state == RESP) & owner_ld & mis_q;
    assign bus.if_data     = if_data_q;
    assign bus.ld_data     = ld_data_q;
    assign bus.rom_en      = (state == ACCESS);
    assign bus.rom_addr    = rom_addr_q;
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: combinational-ROM and registered-ROM instances,
// a vector table, hand sequences for contention/reset, and a randomized timing model.
module tb_rom_access_arbiter;
    localparam int AW = 17;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rom_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    rom_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    rom_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.slave));
    rom_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave));

    function automatic logic [31:0] rom_word(input logic [14:0] idx);
        logic [31:0] x;
        x = {17'd0, idx};
        return (x * 32'h9E3779B1) ^ {idx, 17'h1A5A5};
    endfunction

    assign bus0.rom_data = rom_word(bus0.rom_addr[16:2]);
    always @(posedge clock) bus1.rom_data <= rom_word(bus1.rom_addr[16:2]);

    typedef struct packed {
        logic        if_gnt, if_valid, if_mis;
        logic [31:0] if_data;
        logic        ld_gnt, ld_valid, ld_mis;
        logic [31:0] ld_data;
        logic        rom_en;
        logic [16:0] rom_addr;
    } obs_t;

    typedef struct {
        int          dut;
        bit          who_ld;
        logic [16:0] addr;
        int          exp_lat;
        bit          exp_mis;
        logic [31:0] exp_data;
        int          exp_en;
    } vec_t;

    typedef struct {
        int          at;
        bit          ld;
        bit          mis;
        logic [31:0] data;
    } resp_t;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample(input int d);
        obs_t o;
        if (d == 0)
            o = '{bus0.if_gnt, bus0.if_valid, bus0.if_misalign, bus0.if_data,
                  bus0.ld_gnt, bus0.ld_valid, bus0.ld_misalign, bus0.ld_data,
                  bus0.rom_en, bus0.rom_addr};
        else
            o = '{bus1.if_gnt, bus1.if_valid, bus1.if_misalign, bus1.if_data,
                  bus1.ld_gnt, bus1.ld_valid, bus1.ld_misalign, bus1.ld_data,
                  bus1.rom_en, bus1.rom_addr};
        return o;
    endfunction

    task automatic drive(input int d, input logic ir, input logic [16:0] ia,
                         input logic lr, input logic [16:0] la);
        if (d == 0) begin
            bus0.if_req = ir; bus0.if_addr = ia; bus0.ld_req = lr; bus0.ld_addr = la;
        end else begin
            bus1.if_req = ir; bus1.if_addr = ia; bus1.ld_req = lr; bus1.ld_addr = la;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(0, 1'b0, '0, 1'b0, '0);
        drive(1, 1'b0, '0, 1'b0, '0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    function automatic logic [16:0] rand_addr();
        logic [16:0] a;
        a = 17'($urandom_range(0, 32767)) << 2;
        if ($urandom_range(0, 15) == 0) a = 17'h1FFFC;
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // Single request from one port; measures grant, latency, ROM activity and payload.
    task automatic run_vec(input vec_t v, input int k);
        obs_t        o;
        int          lat = -1;
        int          en = 0;
        bit          vmis = 1'b0;
        bit          other = 1'b0;
        logic [31:0] vdat = '0;
        drive(v.dut, !v.who_ld, v.addr, v.who_ld, v.addr);
        @(negedge clock);
        o = sample(v.dut);
        chk($sformatf("v%0d_gnt", k), {o.if_gnt, o.ld_gnt}, v.who_ld ? 2'b01 : 2'b10);
        step();
        drive(v.dut, 1'b0, '0, 1'b0, '0);
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clock);
            o = sample(v.dut);
            if (o.rom_en) begin
                en++;
                chk($sformatf("v%0d_rom_addr", k), o.rom_addr, v.addr);
            end
            if (v.who_ld ? o.if_valid : o.ld_valid) other = 1'b1;
            if (v.who_ld ? o.ld_valid : o.if_valid) begin
                lat  = c;
                vmis = v.who_ld ? o.ld_mis : o.if_mis;
                vdat = v.who_ld ? o.ld_data : o.if_data;
            end
            step();
        end
        chk($sformatf("v%0d_latency", k), lat, v.exp_lat);
        chk($sformatf("v%0d_misalign", k), vmis, v.exp_mis);
        chk($sformatf("v%0d_data", k), vdat, v.exp_data);
        chk($sformatf("v%0d_rom_en_cycles", k), en, v.exp_en);
        chk($sformatf("v%0d_other_valid", k), other, 1'b0);
        @(negedge clock);
        o = sample(v.dut);
        chk($sformatf("v%0d_data_held", k), v.who_ld ? o.ld_data : o.if_data, v.exp_data);
        step();
    endtask

    task automatic reset_mid(input bit w_ld);
        obs_t o;
        apply_reset();
        drive(0, !w_ld, 17'h00024, w_ld, 17'h00024);
        @(negedge clock);
        o = sample(0);
        chk("rst_mid_gnt", {o.if_gnt, o.ld_gnt}, w_ld ? 2'b01 : 2'b10);
        step();
        drive(0, 1'b0, '0, 1'b0, '0);
        @(negedge clock);
        o = sample(0);
        chk("rst_mid_rom_en", o.rom_en, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        o = sample(0);
        chk("rst_mid_clear", o, '0);
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clock);
            o = sample(0);
            chk("rst_mid_no_valid", {o.if_valid, o.ld_valid, o.rom_en}, 3'b000);
        end
        step();
        drive(0, 1'b1, 17'h00030, 1'b1, 17'h00034);
        @(negedge clock);
        o = sample(0);
        chk("rst_mid_if_first", {o.if_gnt, o.ld_gnt}, 2'b10);
        step();
        drive(0, 1'b0, '0, 1'b0, '0);
        repeat (4) step();
    endtask

    // Transaction-timing model: grants only when the ROM path is free, round-robin on
    // contention, responses scheduled by fixed latency, words from the ROM function.
    task automatic rand_phase(input int d, input int lat, input int ncyc);
        obs_t        o;
        resp_t       q[$];
        resp_t       r;
        int          next_free = 0;
        bit          last_ld = 1'b1;
        bit          rq_i = 1'b0, rq_l = 1'b0;
        logic [16:0] a_i = '0, a_l = '0, a, en_addr = '0;
        logic [31:0] h_i = '0, h_l = '0;
        int          en_lo = -1, en_hi = -2;
        bit          e_gi, e_gl, e_vi, e_vl, e_mi, e_ml, mis, e_en;
        apply_reset();
        for (int c = 0; c < ncyc; c++) begin
            drive(d, rq_i, a_i, rq_l, a_l);
            @(negedge clock);
            o = sample(d);
            e_gi = (c >= next_free) && rq_i && (!rq_l || last_ld);
            e_gl = (c >= next_free) && rq_l && !e_gi;
            chk($sformatf("rnd%0d_gnt", d), {o.if_gnt, o.ld_gnt}, {e_gi, e_gl});
            if (e_gi || e_gl) begin
                a   = e_gl ? a_l : a_i;
                mis = (a[1:0] != 2'b00);
                q.push_back('{at: c + (mis ? 1 : lat + 2), ld: e_gl, mis: mis,
                              data: mis ? 32'd0 : rom_word(a[16:2])});
                if (!mis) begin
                    en_lo = c + 1; en_hi = c + 1 + lat; en_addr = a;
                end
                next_free = c + (mis ? 2 : lat + 3);
                last_ld   = e_gl;
            end
            e_vi = 1'b0; e_vl = 1'b0; e_mi = 1'b0; e_ml = 1'b0;
            if (q.size() > 0 && q[0].at == c) begin
                r = q.pop_front();
                if (r.ld) begin e_vl = 1'b1; e_ml = r.mis; h_l = r.data; end
                else      begin e_vi = 1'b1; e_mi = r.mis; h_i = r.data; end
            end
            chk($sformatf("rnd%0d_valid", d), {o.if_valid, o.if_mis, o.ld_valid, o.ld_mis},
                {e_vi, e_mi, e_vl, e_ml});
            chk($sformatf("rnd%0d_data", d), {o.if_data, o.ld_data}, {h_i, h_l});
            e_en = (c >= en_lo) && (c <= en_hi);
            chk($sformatf("rnd%0d_rom_en", d), o.rom_en, e_en);
            if (e_en) chk($sformatf("rnd%0d_rom_addr", d), o.rom_addr, en_addr);
            if (e_gi) rq_i = 1'b0;
            else if (!rq_i && $urandom_range(0, 2) != 0) begin rq_i = 1'b1; a_i = rand_addr(); end
            if (e_gl) rq_l = 1'b0;
            else if (!rq_l && $urandom_range(0, 2) != 0) begin rq_l = 1'b1; a_l = rand_addr(); end
            step();
        end
        drive(d, 1'b0, '0, 1'b0, '0);
        repeat (5) step();
    endtask

    initial begin
        vec_t        tbl[8];
        obs_t        o;
        int          ig, lg, iv, lv, n;
        bit          ir, lr;
        logic [31:0] idat, ldat;

        tbl[0] = '{0, 1'b0, 17'h00008, 2, 1'b0, rom_word(15'd2), 1};
        tbl[1] = '{0, 1'b0, 17'h00006, 1, 1'b1, 32'd0, 0};
        tbl[2] = '{0, 1'b1, 17'h1FFFC, 2, 1'b0, rom_word(15'h7FFF), 1};
        tbl[3] = '{0, 1'b1, 17'h00001, 1, 1'b1, 32'd0, 0};
        tbl[4] = '{1, 1'b1, 17'h00004, 3, 1'b0, rom_word(15'd1), 2};
        tbl[5] = '{1, 1'b0, 17'h00003, 1, 1'b1, 32'd0, 0};
        tbl[6] = '{1, 1'b0, 17'h1FFFC, 3, 1'b0, rom_word(15'h7FFF), 2};
        tbl[7] = '{0, 1'b0, 17'h00000, 2, 1'b0, rom_word(15'd0), 1};

        reset = 1'b1;
        drive(0, 1'b0, '0, 1'b0, '0);
        drive(1, 1'b0, '0, 1'b0, '0);
        @(posedge clock);
        @(negedge clock);
        chk("reset_dut0", sample(0), '0);
        chk("reset_dut1", sample(1), '0);
        step();
        reset = 1'b0;

        for (int k = 0; k < 8; k++) run_vec(tbl[k], k);

        // Simultaneous IF/LD requests after reset: IF first, LD three cycles later.
        apply_reset();
        ig = -1; lg = -1; iv = -1; lv = -1; ir = 1'b1; lr = 1'b1;
        idat = '0; ldat = '0;
        drive(0, ir, 17'h00008, lr, 17'h00010);
        for (int c = 0; c <= 8; c++) begin
            @(negedge clock);
            o = sample(0);
            if (o.if_gnt && ig < 0) begin ig = c; ir = 1'b0; end
            if (o.ld_gnt && lg < 0) begin lg = c; lr = 1'b0; end
            if (o.if_valid && iv < 0) begin iv = c; idat = o.if_data; end
            if (o.ld_valid && lv < 0) begin lv = c; ldat = o.ld_data; end
            step();
            drive(0, ir, 17'h00008, lr, 17'h00010);
        end
        chk("contend_if_gnt", ig, 0);
        chk("contend_if_valid", iv, 2);
        chk("contend_if_data", idat, rom_word(15'd2));
        chk("contend_ld_gnt", lg, 3);
        chk("contend_ld_valid", lv, 5);
        chk("contend_ld_data", ldat, rom_word(15'd4));

        // Both requests held: strict alternation every three cycles.
        apply_reset();
        n = 0;
        drive(0, 1'b1, 17'h00020, 1'b1, 17'h00040);
        for (int c = 0; c < 30 && n < 6; c++) begin
            @(negedge clock);
            o = sample(0);
            if (o.if_gnt || o.ld_gnt) begin
                chk("rr_order", {o.if_gnt, o.ld_gnt}, (n % 2) ? 2'b01 : 2'b10);
                chk("rr_spacing", c, 3 * n);
                n++;
            end
            step();
        end
        chk("rr_count", n, 6);
        drive(0, 1'b0, '0, 1'b0, '0);
        repeat (4) step();

        reset_mid(1'b1);
        reset_mid(1'b0);

        rand_phase(0, 0, 400);
        rand_phase(1, 1, 400);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
